// File: rtl/branch_ex.sv
// branch_ex -- branch execution stage behind the branch reservation station.
//
// Resolves one issued branch/jump per cycle under static not-taken prediction.
// Every result is registered, so an issue accepted at edge N shows its results
// from edge N until edge N+1.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   workEn               issue valid from the branch RS
//   operandO, operandT   rs1 / rs2 values
//   imm                  sign-extended immediate
//   opCode               operation (encoding below); NOP or unknown = no work
//   PC, tag              instruction address, destination tag for the link value
//   jumpEn, jumpAddr     one-cycle fetch redirect and its target
//   enWrt, wrtTag,       one-cycle CDB write of the JAL/JALR link value (PC+4)
//   wrtData
//   busy                 flush window active; issues are being dropped
//   brCount, missCount   resolved branch/jump count, redirect count (wrap at 2^32)
//
// opCode encoding (4 bits):
//   0 NOP, 1 BEQ, 2 BNE, 3 BLT, 4 BGE, 5 BLTU, 6 BGEU, 7 JAL, 8 JALR,
//   9..15 unknown (treated as NOP)
module branch_ex #(
  parameter int DATA_W       = 32,
  parameter int TAG_W        = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              workEn,
  input  logic [DATA_W-1:0] operandO,
  input  logic [DATA_W-1:0] operandT,
  input  logic [DATA_W-1:0] imm,
  input  logic [3:0]        opCode,
  input  logic [DATA_W-1:0] PC,
  input  logic [TAG_W-1:0]  tag,
  output logic              jumpEn,
  output logic [DATA_W-1:0] jumpAddr,
  output logic              enWrt,
  output logic [TAG_W-1:0]  wrtTag,
  output logic [DATA_W-1:0] wrtData,
  output logic              busy,
  output logic [31:0]       brCount,
  output logic [31:0]       missCount
);

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_BEQ  = 4'd1,
    OP_BNE  = 4'd2,
    OP_BLT  = 4'd3,
    OP_BGE  = 4'd4,
    OP_BLTU = 4'd5,
    OP_BGEU = 4'd6,
    OP_JAL  = 4'd7,
    OP_JALR = 4'd8
  } op_e;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_e;

  localparam int CNT_W = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               jump_en_q, jump_en_d;
  logic [DATA_W-1:0]  jump_addr_q, jump_addr_d;
  logic               en_wrt_q, en_wrt_d;
  logic [TAG_W-1:0]   wrt_tag_q, wrt_tag_d;
  logic [DATA_W-1:0]  wrt_data_q, wrt_data_d;
  logic               busy_q, busy_d;
  logic [31:0]        br_count_q, br_count_d;
  logic [31:0]        miss_count_q, miss_count_d;

  // Decode / resolve (combinational, independent of state)
  logic               op_valid;
  logic               op_taken;
  logic               op_link;
  logic [DATA_W-1:0]  op_target;
  logic [DATA_W-1:0]  pc_rel;
  logic [DATA_W-1:0]  reg_rel;
  logic               eq, lt_s, lt_u;

  always_comb begin
    pc_rel    = PC + imm;
    reg_rel   = operandO + imm;
    eq        = (operandO == operandT);
    lt_s      = ($signed(operandO) < $signed(operandT));
    lt_u      = (operandO < operandT);
    op_valid  = 1'b1;
    op_taken  = 1'b0;
    op_link   = 1'b0;
    op_target = pc_rel;
    case (opCode)
      OP_BEQ:  op_taken = eq;
      OP_BNE:  op_taken = !eq;
      OP_BLT:  op_taken = lt_s;
      OP_BGE:  op_taken = !lt_s;
      OP_BLTU: op_taken = lt_u;
      OP_BGEU: op_taken = !lt_u;
      OP_JAL: begin
        op_taken = 1'b1;
        op_link  = 1'b1;
      end
      OP_JALR: begin
        op_taken  = 1'b1;
        op_link   = 1'b1;
        op_target = {reg_rel[DATA_W-1:1], 1'b0};
      end
      default: op_valid = 1'b0;
    endcase
  end

  // Next-state and registered outputs
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    jump_en_d    = 1'b0;
    jump_addr_d  = '0;
    en_wrt_d     = 1'b0;
    wrt_tag_d    = '0;
    wrt_data_d   = '0;
    busy_d       = 1'b0;
    br_count_d   = br_count_q;
    miss_count_d = miss_count_q;

    case (state_q)
      IDLE: begin
        if (workEn && op_valid) begin
          br_count_d = br_count_q + 32'd1;
          if (op_taken) begin
            jump_en_d    = 1'b1;
            jump_addr_d  = op_target;
            miss_count_d = miss_count_q + 32'd1;
            if (FLUSH_CYCLES > 0) begin
              state_d = FLUSH;
              cnt_d   = CNT_W'(FLUSH_CYCLES);
              busy_d  = 1'b1;
            end
          end
          if (op_link) begin
            en_wrt_d   = 1'b1;
            wrt_tag_d  = tag;
            wrt_data_d = PC + DATA_W'(4);
          end
        end
      end
      FLUSH: begin
        // The counter reaches 0 on this edge when it currently holds 1;
        // busy drops on that same edge so it is high for FLUSH_CYCLES cycles.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          busy_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      jump_en_q    <= 1'b0;
      jump_addr_q  <= '0;
      en_wrt_q     <= 1'b0;
      wrt_tag_q    <= '0;
      wrt_data_q   <= '0;
      busy_q       <= 1'b0;
      br_count_q   <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      jump_en_q    <= jump_en_d;
      jump_addr_q  <= jump_addr_d;
      en_wrt_q     <= en_wrt_d;
      wrt_tag_q    <= wrt_tag_d;
      wrt_data_q   <= wrt_data_d;
      busy_q       <= busy_d;
      br_count_q   <= br_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign jumpEn    = jump_en_q;
  assign jumpAddr  = jump_addr_q;
  assign enWrt     = en_wrt_q;
  assign wrtTag    = wrt_tag_q;
  assign wrtData   = wrt_data_q;
  assign busy      = busy_q;
  assign brCount   = br_count_q;
  assign missCount = miss_count_q;

endmodule

// File: doc/branch_ex.md
Name: branch_ex

Overview:
- Branch execution stage, directly downstream of the branch reservation station. Consumes one issued branch/jump per cycle (workEn, operands, imm, opCode, PC, tag).
- Resolves BEQ/BNE/BLT/BGE/BLTU/BGEU/JAL/JALR under static not-taken prediction.
- Emits a one-cycle fetch redirect and the JAL/JALR link value on the CDB.
- After a redirect, runs a flush window that squashes in-flight issues.

Parameters:
- DATA_W, 32, operand/data/address width
- TAG_W, 4, width of the reorder tag
- FLUSH_CYCLES, 2, cycles new work is squashed after a redirect (0 = no squash window)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- workEn  in  1  issue valid from the branch RS
- operandO  in  DATA_W  rs1 value
- operandT  in  DATA_W  rs2 value
- imm  in  DATA_W  sign-extended immediate
- opCode  in  `OpBus  operation; NOP or unknown means no work
- PC  in  DATA_W  instruction address
- tag  in  TAG_W  destination tag for the link value
- jumpEn  out  1  redirect fetch this cycle
- jumpAddr  out  DATA_W  redirect target
- enWrt  out  1  CDB write valid
- wrtTag  out  TAG_W  CDB tag
- wrtData  out  DATA_W  CDB data (PC+4)
- busy  out  1  flush window active; issues are being dropped
- brCount  out  32  resolved (non-squashed) branch/jump count
- missCount  out  32  redirect count

Behaviour:
- Reset: asynchronous, active-high. Clears all outputs to 0 (jumpEn, jumpAddr, enWrt, wrtTag, wrtData, busy, brCount, missCount), forces state IDLE, clears the flush counter. Reset mid-flush or mid-result drops everything; the first edge after rst deasserts behaves as IDLE.
- States:
  - IDLE: accept work.
  - FLUSH: drop work; a down-counter runs.
- Accept rule: an issue is accepted at a posedge when state==IDLE, workEn=1 and opCode is a recognised branch/jump. All results are registered, so latency is 1 cycle: accept at edge N, results visible from edge N to N+1.
- Result outputs pulse for one cycle only. jumpEn, enWrt and their data return to 0 the next cycle unless a new accept occurs.
- Conditions:
  - BLT/BGE compare operandO vs operandT as signed.
  - BLTU/BGEU compare them as unsigned.
  - BEQ/BNE compare for equality.
- Taken rule: JAL and JALR are always taken.
- Targets:
  - Branches and JAL: PC+imm, modulo 2^DATA_W (wrap-around ignored).
  - JALR: (operandO+imm) with bit0 cleared.
- Link: JAL/JALR drive enWrt=1, wrtTag=tag, wrtData=PC+4 (wraps). Conditional branches never write the CDB (enWrt=0, wrtTag=0, wrtData=0).
- Redirect:
  - Taken: jumpEn=1, jumpAddr=target, missCount+1.
  - Not-taken: jumpEn=0, jumpAddr=0.
  - Every accept: brCount+1. Both counters wrap at 2^32.
- Flush entry: a taken accept with FLUSH_CYCLES>0 moves to FLUSH with counter=FLUSH_CYCLES. With FLUSH_CYCLES=0, the state stays IDLE and back-to-back taken accepts are legal.
- In FLUSH:
  - busy=1 (registered, asserted from the same edge as jumpEn).
  - Each edge decrements the counter. Return to IDLE and busy=0 at the edge where the counter reaches 0, so busy is high for exactly FLUSH_CYCLES cycles.
  - workEn during FLUSH is dropped: no outputs, no counter change, including on the final FLUSH cycle.
- Simultaneous events: workEn with a NOP/unknown opCode in IDLE is ignored entirely. A not-taken accept never changes state.

Test Plan:
1. Reset held 3 cycles, then released with workEn=0: all outputs 0, busy=0, counters 0; reassert rst mid-FLUSH -> busy drops to 0 immediately (async).
2. BEQ, operandO=5, operandT=5, PC=0x100, imm=0x20 -> next cycle jumpEn=1, jumpAddr=0x120, enWrt=0, busy=1 for 2 cycles, missCount=1, brCount=1. Same with operandT=6 -> jumpEn=0, busy=0, missCount unchanged.
3. BLT vs BLTU with operandO=0xFFFFFFFF, operandT=1, PC=0x40, imm=8: BLT taken -> jumpAddr=0x48; BLTU not taken -> jumpEn=0.
4. JALR, operandO=0x1001, imm=0x4, PC=0x200, tag=3 -> jumpAddr=0x1004, enWrt=1, wrtTag=3, wrtData=0x204, all for one cycle only.
5. Taken BNE followed by workEn=1 with valid branches on each of the next 2 cycles -> both squashed: no jumpEn/enWrt, brCount stays 1. A third issue on the cycle after busy falls is accepted.
6. FLUSH_CYCLES=0, JAL PC=0xFFFFFFFC, imm=8, two back-to-back issues -> jumpAddr=0x4 twice, wrtData=0x0 twice, busy never 1, missCount=2.
